// File: rtl/wb4_to_pi1_pkg.sv
// wb4_to_pi1_pkg -- shared definitions for the Wishbone B4 to pi1 bridge.
//   pi1_op_e     : pi1 operation encoding (same codes as the pi1-to-Wishbone bridge)
//   fsm_state_e  : in-flight tracker states of the bridge
//   clog2()      : constant ceil(log2) used for the derived widths
package wb4_to_pi1_pkg;

  typedef enum logic [1:0] {
    PINOOP = 2'b00,
    PIWROP = 2'b01,
    PIRDOP = 2'b10,
    PIRWOP = 2'b11
  } pi1_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,  // no pi1 op in flight
    ST_BUSY = 1'b1   // one pi1 op in flight, waiting for its completion
  } fsm_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/wb4_to_pi1_if.sv
// wb4_to_pi1_if -- Wishbone B4 pipelined slave side plus pi1 master side of
// the bridge, bundled in one interface.
//   slave  modport : the bridge's view (receives Wishbone requests, drives pi1)
//   master modport : the surrounding system's view (Wishbone master + pi1 slave)
// Signals: wb4_cyc_i/stb_i/we_i/addr_i/data_i/sel_i, wb4_stall_o/ack_o/data_o,
//          pi1_op_o/addr_o/data_o/sel_o, pi1_data_i/rdy_i.
interface wb4_to_pi1_if #(
  parameter int ARCHBITSZ = 16
) ();
  import wb4_to_pi1_pkg::*;

  localparam int CLOG2ARCHBITSZBY8 = clog2(ARCHBITSZ / 8);
  localparam int ADDRBITSZ         = ARCHBITSZ - CLOG2ARCHBITSZBY8;

  logic                     wb4_cyc_i;
  logic                     wb4_stb_i;
  logic                     wb4_we_i;
  logic [ARCHBITSZ-1:0]     wb4_addr_i;
  logic [ARCHBITSZ-1:0]     wb4_data_i;
  logic [ARCHBITSZ/8-1:0]   wb4_sel_i;
  logic                     wb4_stall_o;
  logic                     wb4_ack_o;
  logic [ARCHBITSZ-1:0]     wb4_data_o;

  pi1_op_e                  pi1_op_o;
  logic [ADDRBITSZ-1:0]     pi1_addr_o;
  logic [ARCHBITSZ-1:0]     pi1_data_o;
  logic [ARCHBITSZ/8-1:0]   pi1_sel_o;
  logic [ARCHBITSZ-1:0]     pi1_data_i;
  logic                     pi1_rdy_i;

  modport slave (
    input  wb4_cyc_i, wb4_stb_i, wb4_we_i, wb4_addr_i, wb4_data_i, wb4_sel_i,
    output wb4_stall_o, wb4_ack_o, wb4_data_o,
    output pi1_op_o, pi1_addr_o, pi1_data_o, pi1_sel_o,
    input  pi1_data_i, pi1_rdy_i
  );

  modport master (
    output wb4_cyc_i, wb4_stb_i, wb4_we_i, wb4_addr_i, wb4_data_i, wb4_sel_i,
    input  wb4_stall_o, wb4_ack_o, wb4_data_o,
    input  pi1_op_o, pi1_addr_o, pi1_data_o, pi1_sel_o,
    output pi1_data_i, pi1_rdy_i
  );

endinterface

// File: rtl/wb4_to_pi1_reqfifo.sv
// wb4_to_pi1_reqfifo -- request queue of the bridge.
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : drop every stored entry this cycle (has priority)
//   push/push_data : enqueue one entry
//   pop        : dequeue the head entry
//   head_data  : current head entry (meaningless while empty)
//   empty      : no entries stored
//   count      : number of stored entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap by plain rollover.
module wb4_to_pi1_reqfifo
  import wb4_to_pi1_pkg::*;
#(
  parameter  int WIDTH    = 8,
  parameter  int DEPTH    = 4,
  localparam int PTRBITSZ = clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                push,
  input  logic [WIDTH-1:0]    push_data,
  input  logic                pop,
  output logic [WIDTH-1:0]    head_data,
  output logic                empty,
  output logic [PTRBITSZ:0]   count
);

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [PTRBITSZ-1:0] wr_ptr;
  logic [PTRBITSZ-1:0] rd_ptr;
  logic [PTRBITSZ:0]   cnt;
  logic                do_push;
  logic                do_pop;

  // Guard against overflow/underflow even if a caller misbehaves.
  assign do_push = push & ~flush & (cnt != (PTRBITSZ + 1)'(DEPTH));
  assign do_pop  = pop  & ~flush & (cnt != '0);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTRBITSZ'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTRBITSZ'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (PTRBITSZ + 1)'(1);
        2'b01:   cnt <= cnt - (PTRBITSZ + 1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // NOTE: the storage array has no reset; entries are only ever read after
  // being written, and leaving it unreset lets it map onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head_data = mem[rd_ptr];
  assign empty     = (cnt == '0);
  assign count     = cnt;

endmodule

// File: rtl/wb4_to_pi1.sv
// wb4_to_pi1 -- Wishbone B4 pipelined slave to pi1 master bridge.
//   wb4_clk_i : single clock for both sides
//   wb4_rst_i : asynchronous active-low reset
//   bus       : wb4_to_pi1_if.slave (Wishbone request/ack side, pi1 op side)
// Accepted Wishbone requests are queued, replayed as pi1 ops with one op in
// flight, and acknowledged in order one cycle after their pi1 completion.
// Dropping wb4_cyc_i flushes the queue and silences the in-flight op's ack.
module wb4_to_pi1
  import wb4_to_pi1_pkg::*;
#(
  parameter int ARCHBITSZ = 16,
  parameter int FIFODEPTH = 4
) (
  input  logic            wb4_clk_i,
  input  logic            wb4_rst_i,
  wb4_to_pi1_if.slave     bus
);

  localparam int CLOG2ARCHBITSZBY8 = clog2(ARCHBITSZ / 8);
  localparam int ADDRBITSZ         = ARCHBITSZ - CLOG2ARCHBITSZBY8;
  localparam int SELBITSZ          = ARCHBITSZ / 8;
  localparam int CNTBITSZ          = clog2(FIFODEPTH) + 1;

  typedef struct packed {
    logic                 we;
    logic [ADDRBITSZ-1:0] addr;
    logic [ARCHBITSZ-1:0] data;
    logic [SELBITSZ-1:0]  sel;
  } req_t;

  localparam int REQBITSZ = $bits(req_t);

  // ---------------------------------------------------------------- request queue
  req_t                push_req;
  req_t                head_req;
  logic [REQBITSZ-1:0] head_raw;
  logic [CNTBITSZ-1:0] fifo_count;
  logic                fifo_empty;
  logic                stall;
  logic                accept;
  logic                flush;
  logic                issue_valid;
  logic                pop;
  logic                unused_addr_lsbs;

  // Stall looks only at the registered count: a full queue stalls even when
  // it pops in the same cycle, keeping stall off any combinational pi1 path.
  assign stall  = (fifo_count == CNTBITSZ'(FIFODEPTH));
  assign accept = bus.wb4_cyc_i & bus.wb4_stb_i & ~stall;
  assign flush  = ~bus.wb4_cyc_i;

  // Byte lanes travel in sel; the low byte-address bits carry no information.
  assign push_req = '{
    we:   bus.wb4_we_i,
    addr: bus.wb4_addr_i[ARCHBITSZ-1:CLOG2ARCHBITSZBY8],
    data: bus.wb4_data_i,
    sel:  bus.wb4_sel_i
  };
  assign unused_addr_lsbs = ^bus.wb4_addr_i[CLOG2ARCHBITSZBY8-1:0];

  wb4_to_pi1_reqfifo #(
    .WIDTH (REQBITSZ),
    .DEPTH (FIFODEPTH)
  ) u_reqfifo (
    .clk       (wb4_clk_i),
    .rst_n     (wb4_rst_i),
    .flush     (flush),
    .push      (accept),
    .push_data (push_req),
    .pop       (pop),
    .head_data (head_raw),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign head_req    = req_t'(head_raw);
  assign issue_valid = bus.wb4_cyc_i & ~fifo_empty;
  assign pop         = issue_valid & bus.pi1_rdy_i;

  // ---------------------------------------------------------------- pi1 issue
  logic [ADDRBITSZ-1:0] hold_addr_q;
  logic [ARCHBITSZ-1:0] hold_data_q;
  logic [SELBITSZ-1:0]  hold_sel_q;

  always_comb begin
    bus.pi1_op_o   = PINOOP;
    bus.pi1_addr_o = hold_addr_q;
    bus.pi1_data_o = hold_data_q;
    bus.pi1_sel_o  = hold_sel_q;
    if (issue_valid) begin
      bus.pi1_op_o   = head_req.we ? PIWROP : PIRDOP;
      bus.pi1_addr_o = head_req.addr;
      bus.pi1_data_o = head_req.data;
      bus.pi1_sel_o  = head_req.sel;
    end
  end

  // ---------------------------------------------------------------- in-flight FSM
  fsm_state_e           state_q, state_d;
  logic                 drop_q, drop_d;           // in-flight op belongs to an aborted cycle
  logic                 rd_inflight_q, rd_inflight_d;
  logic                 ack_q, ack_d;
  logic [ARCHBITSZ-1:0] rdata_q;
  logic                 complete;

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    drop_d        = drop_q;
    rd_inflight_d = rd_inflight_q;
    ack_d         = 1'b0;
    complete      = 1'b0;

    if (bus.pi1_rdy_i) begin
      complete = (state_q == ST_BUSY);
      // A completion that coincides with cyc low belongs to the aborted
      // cycle as well, so it is silenced like any other dropped op.
      ack_d    = complete & ~drop_q & bus.wb4_cyc_i;
      if (pop) begin
        state_d       = ST_BUSY;
        drop_d        = 1'b0;
        rd_inflight_d = ~head_req.we;
      end else if (complete) begin
        state_d = ST_IDLE;
        drop_d  = 1'b0;
      end
    end

    // Abort while an op stays in flight: let it finish on pi1 but never ack
    // it, so a freshly started cycle cannot receive a stale ack.
    if (!bus.wb4_cyc_i && state_d == ST_BUSY) drop_d = 1'b1;
  end

  always_ff @(posedge wb4_clk_i or negedge wb4_rst_i) begin
    if (!wb4_rst_i) begin
      state_q       <= ST_IDLE;
      drop_q        <= 1'b0;
      rd_inflight_q <= 1'b0;
      ack_q         <= 1'b0;
      rdata_q       <= '0;
      hold_addr_q   <= '0;
      hold_data_q   <= '0;
      hold_sel_q    <= '0;
    end else begin
      state_q       <= state_d;
      drop_q        <= drop_d;
      rd_inflight_q <= rd_inflight_d;
      ack_q         <= ack_d;
      if (ack_d) rdata_q <= rd_inflight_q ? bus.pi1_data_i : '0;
      if (issue_valid) begin
        hold_addr_q <= head_req.addr;
        hold_data_q <= head_req.data;
        hold_sel_q  <= head_req.sel;
      end
    end
  end

  assign bus.wb4_stall_o = stall;
  assign bus.wb4_ack_o   = ack_q;
  assign bus.wb4_data_o  = rdata_q;

endmodule

// File: doc/wb4_to_pi1.md
# wb4_to_pi1

Bridge that lets a Wishbone B4 pipelined master reach a PerInt (pi1) slave. It sits on the Wishbone side as a slave, queues accepted requests in a small FIFO, and replays them as pi1 master operations (PIRDOP/PIWROP) with one pi1 operation in flight. It returns one `wb4_ack_o` per accepted request, in order. It is the counterpart of the existing pi1-to-Wishbone master bridge.

## Interface
- `ARCHBITSZ`, 16: data width; 16, 32, 64, 128 or 256.
- `FIFODEPTH`, 4: request FIFO entries; power of two, at least 2.
- Derived: `CLOG2ARCHBITSZBY8 = clog2(ARCHBITSZ/8)`; `ADDRBITSZ = ARCHBITSZ - CLOG2ARCHBITSZBY8`.

Ports:
- `wb4_clk_i`  in  1  single clock for both sides.
- `wb4_rst_i`  in  1  reset; asynchronous assert, active-low.
- `wb4_cyc_i`, `wb4_stb_i`, `wb4_we_i`  in  1 each  Wishbone cycle, strobe, write enable.
- `wb4_addr_i`  in  ARCHBITSZ  byte address.
- `wb4_data_i`  in  ARCHBITSZ  write data.
- `wb4_sel_i`  in  ARCHBITSZ/8  byte lanes.
- `wb4_stall_o`  out  1  request not accepted this cycle.
- `wb4_ack_o`  out  1  one-cycle completion pulse.
- `wb4_data_o`  out  ARCHBITSZ  read data, valid with `wb4_ack_o`.
- `pi1_op_o`  out  2  pi1 operation.
- `pi1_addr_o`  out  ADDRBITSZ  pi1 word address.
- `pi1_data_o`  out  ARCHBITSZ  pi1 write data.
- `pi1_sel_o`  out  ARCHBITSZ/8  pi1 byte lanes.
- `pi1_data_i`  in  ARCHBITSZ  pi1 read data.
- `pi1_rdy_i`  in  1  pi1 ready.

## Operation
- **Accept rule:** a request is accepted when `cyc & stb & !stall`. It is pushed as `{we, addr[ARCHBITSZ-1:CLOG2ARCHBITSZBY8], data, sel}`.
  - Low byte-address bits are dropped; lane selection is carried by `sel` alone.
  - `sel` is forwarded unchanged, including all-zero.
- **Stall:** `wb4_stall_o = (count == FIFODEPTH)`. It is a pure function of the registered count, with no pop bypass, so a full FIFO with a simultaneous pop still stalls.
- **Issue:** when the FIFO is non-empty and `wb4_cyc_i` is high, the pi1 outputs present the head entry.
  - `pi1_op_o` is PIWROP for a write, PIRDOP for a read, otherwise PINOOP.
  - `pi1_addr_o`, `pi1_data_o` and `pi1_sel_o` follow the head entry; when op is PINOOP they hold the last head value.
  - PIRWOP is never generated.
- **pi1 handshake:** in any cycle with `pi1_rdy_i = 1`:
  - the presented op (if not PINOOP) is accepted and popped;
  - the previously accepted op, if any, completes, and `pi1_data_i` carries its read data.
  - With `pi1_rdy_i = 0`, the outputs are held stable and nothing pops or completes.
- **State machine:**
  - IDLE means no op in flight. A rdy cycle with a non-NOOP op goes to BUSY.
  - BUSY means one op in flight. A rdy cycle completes it; the FSM stays in BUSY if a new op was accepted in the same cycle, else returns to IDLE.
- **Completion:** the cycle after a completion, `wb4_ack_o = 1` for one cycle.
  - `wb4_data_o` is the registered `pi1_data_i` for a read, and zero for a write.
  - Otherwise `wb4_ack_o = 0` and `wb4_data_o` holds its value.
- **Abort:** when `wb4_cyc_i` goes low, all un-issued FIFO entries are flushed the same cycle, and `pi1_op_o` is PINOOP.
  - An in-flight op is marked dropped; it still completes on pi1, but its ack is suppressed.
  - A new cycle may start immediately; its first ack cannot alias a dropped completion.

## Timing
- **Reset values:** `wb4_stall_o` 0, `wb4_ack_o` 0, `wb4_data_o` 0, `pi1_op_o` PINOOP, `pi1_addr_o` 0, `pi1_data_o` 0, `pi1_sel_o` 0; FIFO empty, FSM IDLE, drop flag clear.
- **Reset mid-operation:** the in-flight op is abandoned and no ack is produced for it.
- **Minimum latency:** with `pi1_rdy_i` constantly high, a request accepted at cycle N gives `wb4_ack_o` at N+3:
  - push at N;
  - pi1 issue at N+1;
  - completion at N+2;
  - registered ack at N+3.
- **Throughput:** one request per cycle with `pi1_rdy_i` high; with FIFODEPTH ≥ 2, `wb4_stall_o` never asserts.
- **Ordering:** acks are in request order; the ack count equals the accepted-request count, except for aborted requests.

## Structure
- **Shared include `lib/perint/pi1op.v`:** PINOOP=2'b00, PIWROP=2'b01, PIRDOP=2'b10, PIRWOP=2'b11. The pi1-to-Wishbone bridge uses it too.
- **`lib/clog2.v`:** reused for the derived widths.
- **Sub-module `wb4_to_pi1_reqfifo`:** synchronous FIFO with a flush input, width `1+ADDRBITSZ+ARCHBITSZ+ARCHBITSZ/8`, depth FIFODEPTH. Wrap-around is by power-of-two pointer rollover; its count output drives stall.

## Test plan
- **Single read:** ARCHBITSZ=32, rdy high, read at addr 0x0000_0104 with sel 4'b1111 -> pi1 PIRDOP at addr 0x41 one cycle later. Slave returns 0xDEADBEEF -> `wb4_ack_o` with `wb4_data_o`=0xDEADBEEF exactly 3 cycles after accept.
- **Write with lanes:** write 0x11223344 to 0x0000_0106 with sel 4'b1100 -> PIWROP at addr 0x41 with sel 4'b1100 and data 0x11223344; ack carries data 0.
- **Back-to-back:** 8 back-to-back requests, rdy high -> stall never asserts, 8 acks on consecutive cycles, in order.
- **FIFO full:** rdy low for 10 cycles while 6 requests are offered, FIFODEPTH=4 -> stall high after 4 accepts and stays high while rdy is low. The remaining 2 are accepted after rdy rises; 6 acks total.
- **Abort:** drop `cyc` with 1 op in flight and 2 queued -> `pi1_op_o` is PINOOP the same cycle, the in-flight op completes with no ack, and no further pi1 ops are issued. A new single-read cycle then yields exactly 1 ack.
- **Async reset:** assert `wb4_rst_i` low mid-burst, off the clock edge -> all outputs go to reset values immediately; after release, a single read completes normally.
